id_ctrl: RTL and testbench
==========================

ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 instr_req  out  1  fetch request, with PC as address; instr_ack  in  1  fetch accept; instr_data  in  32  instruction, valid when instr_ack=1.
REQ-005 PC  out  32  current instruction address, also EX operand-1 source.
REQ-006 RegAddr1, RegAddr2  out  5  rs1/rs2 read addresses; DataOutReg1, DataOutReg2  in  32  combinational register-file read data.
REQ-007 ALUop_o  out  5  EX operation code; ALUSrc1  out  1  1=PC as operand 1; ALUSrc2  out  1  1=Imm as operand 2; Imm  out  32  sign-extended immediate.
REQ-008 ALUOut  in  32  EX result, combinational from the above.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_ack  in  1; mem_rdata  in  32 (valid with mem_ack).
REQ-010 RegWrite  out  1  one-cycle write strobe; RegWAddr  out  5; RegWData  out  32.
REQ-011 illegal  out  1  sticky flag, unsupported opcode seen.

Function
REQ-012 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH and MEM, which wait for acknowledge.
REQ-013 FETCH: instr_req=1 until instr_ack=1 sampled; on that edge, latch instr_data into IR and go to DECODE.
REQ-014 DECODE: drive RegAddr1=IR[19:15], RegAddr2=IR[24:20], and register Imm and ALUop_o per REQ-015/016; go to EXEC, or HALT with illegal=1 for an unlisted opcode/funct.
REQ-015 ALUop_o codes: beq 10001, lw 10100, jalr 10100, sw 10101, addi 01100, add 01101, sub 01110, sll 01000, xor 00110, srl 01001, or 00101, and 00100; 00000 outside EXEC/MEM.
REQ-016 Imm: I-type {20{IR[31]},IR[31:20]}; S-type {20{IR[31]},IR[31:25],IR[11:7]}; B-type {19{IR[31]},IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
REQ-017 ALUSrc1=1 only for beq; ALUSrc2=1 for beq, lw, sw, addi, jalr; both 0 for R-type.
REQ-018 EXEC: latch ALUOut into result register R.
REQ-018a EXEC, lw/sw: go to MEM.
REQ-018b EXEC, beq: if DataOutReg1==DataOutReg2 then PC<=ALUOut, else PC<=PC+4; go to FETCH.
REQ-018c EXEC, all others: go to WB.
REQ-019 MEM: mem_req=1, mem_addr=R, mem_we=1 for sw with mem_wdata=DataOutReg2; hold stable until mem_ack=1. On ack: sw -> PC<=PC+4, go to FETCH; lw -> latch mem_rdata, go to WB.
REQ-020 WB: RegWrite=1 for exactly one cycle, RegWAddr=IR[11:7]; RegWData = mem data (lw), PC+4 (jalr), R (others).
REQ-020a WB: PC<=PC+4, except jalr, where PC<={R[31:1],1'b0}; go to FETCH.
REQ-021 Writes with RegWAddr=0 SHALL still pulse RegWrite; the register file ignores x0.
REQ-022 PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
REQ-023 HALT is terminal until reset; all request and strobe outputs are 0 in HALT.
REQ-024 instr_ack/mem_ack asserted outside the matching request state SHALL be ignored.
REQ-025 Latency per instruction from ack: R/I-ALU 3 cycles after instr_ack (DECODE, EXEC, WB); beq 2; lw/sw 2 plus memory wait plus WB for lw.

Reset
REQ-026 While rst=0: state=FETCH, PC=RESET_PC, IR=0, R=0, ALUop_o=0, Imm=0, ALUSrc1=ALUSrc2=0, instr_req=0, mem_req=0, mem_we=0, RegWrite=0, illegal=0.
REQ-027 instr_req rises on the first rising clk edge after rst deasserts.
REQ-028 Reset asserted mid-operation, including in MEM with mem_req=1, SHALL drop all requests asynchronously and discard the in-flight instruction; no RegWrite is issued.

Verification
REQ-029 addi x1,x0,5 with ack on first cycle -> WB cycle: RegWrite=1, RegWAddr=1, RegWData=5; PC 0->4.
REQ-030 beq with DataOutReg1=DataOutReg2=7, Imm=-8, PC=0x20 -> PC=0x18; with unequal operands -> PC=0x24; RegWrite never asserted.
REQ-031 sw with mem_ack delayed 3 cycles -> mem_req, mem_addr, mem_wdata held stable for 4 cycles; mem_we=1; no RegWrite.
REQ-032 lw with mem_rdata=0xDEADBEEF -> RegWData=0xDEADBEEF one cycle after ack.
REQ-033 Opcode 7'b1111111 -> illegal=1, state HALT, instr_req stays 0 until reset.
REQ-034 rst pulsed low during MEM wait -> mem_req=0 immediately, PC=RESET_PC, fetch restarts.

Source files
------------

// File: rtl/id_ctrl.sv
// id_ctrl: multi-cycle fetch/decode/execute/memory/writeback controller for an RV32I subset.
module id_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr_data,
  output logic [31:0] PC,
  output logic [4:0]  RegAddr1,
  output logic [4:0]  RegAddr2,
  input  logic [31:0] DataOutReg1,
  input  logic [31:0] DataOutReg2,
  output logic [4:0]  ALUop_o,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [31:0] Imm,
  input  logic [31:0] ALUOut,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  RegWAddr,
  output logic [31:0] RegWData,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] ir, r;
  logic [XLEN-1:0] pc_plus4;

  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_src1, dec_src2, dec_legal;
  logic            is_lw, is_sw, is_beq, is_jalr;
  logic            fetch_hs, mem_hs;

  assign RegAddr1 = ir[19:15];
  assign RegAddr2 = ir[24:20];
  assign mem_addr = r;
  assign pc_plus4 = PC + XLEN'(4);
  assign fetch_hs = (state == FETCH) && instr_req && instr_ack;
  assign mem_hs   = (state == MEM) && mem_req && mem_ack;

  // Instruction decode from the held IR: op code, immediate, operand selects, class flags.
  always_comb begin
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    dec_op    = '0;
    dec_imm   = '0;
    dec_src1  = 1'b0;
    dec_src2  = 1'b0;
    dec_legal = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_jalr   = 1'b0;
    imm_i = {{20{ir[31]}}, ir[31:20]};
    imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    case (ir[6:0])
      7'b1100011: if (ir[14:12] == 3'b000) begin
        dec_op = 5'b10001; dec_imm = imm_b; dec_src1 = 1'b1; dec_src2 = 1'b1;
        dec_legal = 1'b1; is_beq = 1'b1;
      end
      7'b0000011: if (ir[14:12] == 3'b010) begin
        dec_op = 5'b10100; dec_imm = imm_i; dec_src2 = 1'b1; dec_legal = 1'b1; is_lw = 1'b1;
      end
      7'b1100111: if (ir[14:12] == 3'b000) begin
        dec_op = 5'b10100; dec_imm = imm_i; dec_src2 = 1'b1; dec_legal = 1'b1; is_jalr = 1'b1;
      end
      7'b0100011: if (ir[14:12] == 3'b010) begin
        dec_op = 5'b10101; dec_imm = imm_s; dec_src2 = 1'b1; dec_legal = 1'b1; is_sw = 1'b1;
      end
      7'b0010011: if (ir[14:12] == 3'b000) begin
        dec_op = 5'b01100; dec_imm = imm_i; dec_src2 = 1'b1; dec_legal = 1'b1;
      end
      7'b0110011: begin
        dec_legal = 1'b1;
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: dec_op = 5'b01101;
          10'b0100000_000: dec_op = 5'b01110;
          10'b0000000_001: dec_op = 5'b01000;
          10'b0000000_100: dec_op = 5'b00110;
          10'b0000000_101: dec_op = 5'b01001;
          10'b0000000_110: dec_op = 5'b00101;
          10'b0000000_111: dec_op = 5'b00100;
          default:         dec_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // Next-state logic; FETCH and MEM wait for their own acknowledge only.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (fetch_hs) state_nxt = DECODE;
      DECODE:  state_nxt = dec_legal ? EXEC : HALT;
      EXEC: begin
        if (is_lw || is_sw) state_nxt = MEM;
        else if (is_beq)    state_nxt = FETCH;
        else                state_nxt = WB;
      end
      MEM:     if (mem_hs) state_nxt = is_sw ? FETCH : WB;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // Registered outputs and datapath registers, all driven from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC        <= RESET_PC;
      ir        <= '0;
      r         <= '0;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      RegWrite  <= 1'b0;
      RegWAddr  <= '0;
      RegWData  <= '0;
      ALUop_o   <= '0;
      ALUSrc1   <= 1'b0;
      ALUSrc2   <= 1'b0;
      Imm       <= '0;
      illegal   <= 1'b0;
    end else begin
      instr_req <= (state_nxt == FETCH);
      mem_req   <= (state_nxt == MEM);
      mem_we    <= (state_nxt == MEM) && is_sw;
      RegWrite  <= (state_nxt == WB);
      ALUop_o   <= ((state_nxt == EXEC) || (state_nxt == MEM)) ? dec_op : '0;
      case (state)
        FETCH: if (fetch_hs) ir <= instr_data;
        DECODE: begin
          Imm     <= dec_imm;
          ALUSrc1 <= dec_src1;
          ALUSrc2 <= dec_src2;
          if (!dec_legal) illegal <= 1'b1;
        end
        EXEC: begin
          r <= ALUOut;
          if (is_beq) PC <= (DataOutReg1 == DataOutReg2) ? ALUOut : pc_plus4;
          if (is_sw) mem_wdata <= DataOutReg2;
          if (state_nxt == WB) begin
            RegWAddr <= ir[11:7];
            RegWData <= is_jalr ? pc_plus4 : ALUOut;
          end
        end
        MEM: if (mem_hs) begin
          if (is_sw) begin
            PC <= pc_plus4;
          end else begin
            RegWAddr <= ir[11:7];
            RegWData <= mem_rdata;
          end
        end
        WB: PC <= is_jalr ? {r[31:1], 1'b0} : pc_plus4;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// Directed testbench for id_ctrl: one task per scenario, hand-computed expectations.
module tb_id_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_ack;
  logic [31:0] instr_data, PC;
  logic [4:0]  RegAddr1, RegAddr2;
  logic [31:0] DataOutReg1, DataOutReg2;
  logic [4:0]  ALUop_o;
  logic        ALUSrc1, ALUSrc2;
  logic [31:0] Imm, ALUOut;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        RegWrite;
  logic [4:0]  RegWAddr;
  logic [31:0] RegWData;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  id_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
    .PC(PC), .RegAddr1(RegAddr1), .RegAddr2(RegAddr2),
    .DataOutReg1(DataOutReg1), .DataOutReg2(DataOutReg2),
    .ALUop_o(ALUop_o), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .Imm(Imm), .ALUOut(ALUOut),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .RegWAddr(RegWAddr), .RegWData(RegWData), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for a fetch request at a falling edge, then acknowledge it for one cycle.
  task automatic do_fetch(input logic [31:0] ins);
    int k = 0;
    while (instr_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: instr_req=%b want 1", instr_req); end
    instr_data = ins; instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; instr_ack = 0; instr_data = 0; mem_ack = 0; mem_rdata = 0;
    DataOutReg1 = 0; DataOutReg2 = 0; ALUOut = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL rst_instr_req: got %b want 0", instr_req); end
    n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", PC); end
    n_cmp++; if ({mem_req, mem_we, RegWrite, illegal, ALUSrc1, ALUSrc2} !== 6'b0) begin
      n_err++; $display("FAIL rst_flags: got %b want 000000", {mem_req, mem_we, RegWrite, illegal, ALUSrc1, ALUSrc2}); end
    n_cmp++; if (ALUop_o !== 5'd0 || Imm !== 32'h0) begin n_err++; $display("FAIL rst_op_imm: got %h/%h want 0/0", ALUop_o, Imm); end
    rst = 1'b1;
    #1;
    n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL rel_req_early: got %b want 0", instr_req); end
    @(negedge clk);
    n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL rel_req_rise: got %b want 1", instr_req); end
  endtask

  // addi x1,x0,5 from PC 0, acknowledged on the first request cycle.
  task automatic test_addi;
    ALUOut = 32'd5;
    do_fetch(32'h0050_0093);
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b01100) begin n_err++; $display("FAIL addi_op: got %b want 01100", ALUop_o); end
    n_cmp++; if (Imm !== 32'd5) begin n_err++; $display("FAIL addi_imm: got %h want 5", Imm); end
    n_cmp++; if ({ALUSrc1, ALUSrc2} !== 2'b01) begin n_err++; $display("FAIL addi_src: got %b want 01", {ALUSrc1, ALUSrc2}); end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd1 || RegWData !== 32'd5) begin
      n_err++; $display("FAIL addi_wb: got we=%b a=%0d d=%h want 1/1/5", RegWrite, RegWAddr, RegWData); end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0 || PC !== 32'h4) begin n_err++; $display("FAIL addi_after: got we=%b pc=%h want 0/4", RegWrite, PC); end
  endtask

  // sub x3,x1,x2 with a stray mem_ack held high the whole time.
  task automatic test_rtype;
    ALUOut = 32'hFFFF_FFFE; mem_ack = 1'b1;
    do_fetch(32'h4020_81B3);
    n_cmp++; if (RegAddr1 !== 5'd1 || RegAddr2 !== 5'd2) begin n_err++; $display("FAIL sub_raddr: got %0d/%0d want 1/2", RegAddr1, RegAddr2); end
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b01110 || ALUSrc2 !== 1'b0 || ALUSrc1 !== 1'b0) begin
      n_err++; $display("FAIL sub_op: got %b src=%b%b want 01110 src=00", ALUop_o, ALUSrc1, ALUSrc2); end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd3 || RegWData !== 32'hFFFF_FFFE || mem_req !== 1'b0) begin
      n_err++; $display("FAIL sub_wb: got we=%b a=%0d d=%h mreq=%b want 1/3/fffffffe/0", RegWrite, RegWAddr, RegWData, mem_req); end
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++; if (PC !== 32'h8) begin n_err++; $display("FAIL sub_pc: got %h want 8", PC); end
  endtask

  // jalr x5,16(x1) at PC 8; target 0x21 has its low bit cleared.
  task automatic test_jalr;
    ALUOut = 32'h21;
    do_fetch(32'h0100_82E7);
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b10100 || Imm !== 32'h10) begin n_err++; $display("FAIL jalr_op: got %b/%h want 10100/10", ALUop_o, Imm); end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd5 || RegWData !== 32'hC) begin
      n_err++; $display("FAIL jalr_wb: got we=%b a=%0d d=%h want 1/5/c", RegWrite, RegWAddr, RegWData); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'h20) begin n_err++; $display("FAIL jalr_pc: got %h want 20", PC); end
  endtask

  // beq with Imm=-8 at PC 0x20: taken to 0x18, then not taken to 0x1C.
  task automatic test_beq;
    DataOutReg1 = 32'd7; DataOutReg2 = 32'd7; ALUOut = 32'h18;
    do_fetch(32'hFE20_8CE3);
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b10001 || Imm !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL beq_op: got %b/%h want 10001/fffffff8", ALUop_o, Imm); end
    n_cmp++; if ({ALUSrc1, ALUSrc2} !== 2'b11) begin n_err++; $display("FAIL beq_src: got %b want 11", {ALUSrc1, ALUSrc2}); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'h18 || RegWrite !== 1'b0 || instr_req !== 1'b1) begin
      n_err++; $display("FAIL beq_taken: got pc=%h we=%b req=%b want 18/0/1", PC, RegWrite, instr_req); end
    DataOutReg2 = 32'd8; ALUOut = 32'h10;
    do_fetch(32'hFE20_8CE3);
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL beq_nt_we: got %b want 0", RegWrite); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'h1C || RegWrite !== 1'b0) begin n_err++; $display("FAIL beq_nt_pc: got pc=%h we=%b want 1c/0", PC, RegWrite); end
  endtask

  // sw x2,12(x1) with the memory acknowledge arriving on the fourth request cycle.
  task automatic test_sw;
    ALUOut = 32'h100C; DataOutReg2 = 32'hCAFE_F00D;
    do_fetch(32'h0020_A623);
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b10101 || Imm !== 32'hC) begin n_err++; $display("FAIL sw_op: got %b/%h want 10101/c", ALUop_o, Imm); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100C || mem_wdata !== 32'hCAFE_F00D || RegWrite !== 1'b0) begin
        n_err++; $display("FAIL sw_hold%0d: got req=%b we=%b a=%h d=%h rw=%b want 1/1/100c/cafef00d/0", i, mem_req, mem_we, mem_addr, mem_wdata, RegWrite); end
      if (i == 3) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || RegWrite !== 1'b0 || PC !== 32'h20) begin
      n_err++; $display("FAIL sw_done: got req=%b rw=%b pc=%h want 0/0/20", mem_req, RegWrite, PC); end
  endtask

  // lw x7,4(x1) returning 0xDEADBEEF on the first memory cycle.
  task automatic test_lw;
    ALUOut = 32'h2000;
    do_fetch(32'h0040_A383);
    @(negedge clk);
    n_cmp++; if (ALUop_o !== 5'b10100) begin n_err++; $display("FAIL lw_op: got %b want 10100", ALUop_o); end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h2000) begin
      n_err++; $display("FAIL lw_mem: got req=%b we=%b a=%h want 1/0/2000", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd7 || RegWData !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      n_err++; $display("FAIL lw_wb: got we=%b a=%0d d=%h req=%b want 1/7/deadbeef/0", RegWrite, RegWAddr, RegWData, mem_req); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'h24 || RegWrite !== 1'b0) begin n_err++; $display("FAIL lw_pc: got pc=%h we=%b want 24/0", PC, RegWrite); end
  endtask

  // Reset pulse while a store waits in MEM.
  task automatic test_reset_in_mem;
    ALUOut = 32'h3000;
    do_fetch(32'h0020_A623);
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_pre: mem_req=%b want 1", mem_req); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || instr_req !== 1'b0 || PC !== 32'h0) begin
      n_err++; $display("FAIL rm_async: got req=%b we=%b ireq=%b pc=%h want 0/0/0/0", mem_req, mem_we, instr_req, PC); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_req !== 1'b1 || RegWrite !== 1'b0 || PC !== 32'h0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL rm_restart: got ireq=%b rw=%b pc=%h mreq=%b want 1/0/0/0", instr_req, RegWrite, PC, mem_req); end
  endtask

  // Jump to 0xFFFFFFFC, then addi x0 there: x0 write still strobes and PC wraps to 0.
  task automatic test_wrap;
    ALUOut = 32'hFFFF_FFFD;
    do_fetch(32'h0000_8067);
    repeat (2) @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd0 || RegWData !== 32'h4) begin
      n_err++; $display("FAIL wrap_jalr_wb: got we=%b a=%0d d=%h want 1/0/4", RegWrite, RegWAddr, RegWData); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc_top: got %h want fffffffc", PC); end
    ALUOut = 32'h0;
    do_fetch(32'h0000_0013);
    repeat (2) @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RegWAddr !== 5'd0) begin n_err++; $display("FAIL wrap_x0_we: got we=%b a=%0d want 1/0", RegWrite, RegWAddr); end
    @(negedge clk);
    n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", PC); end
  endtask

  // Opcode 1111111 halts with illegal set; stray acknowledges change nothing until reset.
  task automatic test_illegal;
    do_fetch(32'h0000_007F);
    @(negedge clk);
    n_cmp++; if (illegal !== 1'b1 || instr_req !== 1'b0 || ALUop_o !== 5'd0) begin
      n_err++; $display("FAIL ill_halt: got ill=%b req=%b op=%b want 1/0/00000", illegal, instr_req, ALUop_o); end
    instr_ack = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (instr_req !== 1'b0 || mem_req !== 1'b0 || RegWrite !== 1'b0 || illegal !== 1'b1) begin
        n_err++; $display("FAIL ill_stay%0d: got req=%b mreq=%b rw=%b ill=%b want 0/0/0/1", i, instr_req, mem_req, RegWrite, illegal); end
    end
    instr_ack = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b want 0", illegal); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL ill_refetch: got %b want 1", instr_req); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_rtype;
    test_jalr;
    test_beq;
    test_sw;
    test_lw;
    test_reset_in_mem;
    test_wrap;
    test_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
